// File: rtl/tilt_classifier.sv
// Block-averages signed X-axis samples, classifies the average with hysteresis,
// and commits a new tilt code only after DWELL consecutive agreeing averages.
module tilt_classifier #(
    parameter int unsigned SAMPLE_W = 12,
    parameter int unsigned AVG_LOG2 = 2,
    parameter int          ENTER_TH = 300,
    parameter int          EXIT_TH  = 150,
    parameter int unsigned DWELL    = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       sample_valid,
    input  logic signed [SAMPLE_W-1:0] sample_x,
    output logic [1:0]                 tilt,
    output logic                       tilt_change,
    output logic signed [SAMPLE_W-1:0] avg_x
);

    localparam int unsigned ACC_W = SAMPLE_W + AVG_LOG2;
    localparam int unsigned CNT_W = 8;

    localparam logic signed [SAMPLE_W-1:0] ENTER_POS = SAMPLE_W'(ENTER_TH);
    localparam logic signed [SAMPLE_W-1:0] ENTER_NEG = SAMPLE_W'(-ENTER_TH);
    localparam logic signed [SAMPLE_W-1:0] EXIT_POS  = SAMPLE_W'(EXIT_TH);
    localparam logic signed [SAMPLE_W-1:0] EXIT_NEG  = SAMPLE_W'(-EXIT_TH);
    localparam logic [CNT_W-1:0]           DWELL_CNT = CNT_W'(DWELL);
    localparam logic [AVG_LOG2-1:0]        LAST_SMP  = {AVG_LOG2{1'b1}};

    // State encoding doubles as the tilt code driven to letter_decoder.
    typedef enum logic [1:0] {
        TILT_NEUTRAL = 2'b00,
        TILT_LEFT    = 2'b01,
        TILT_RIGHT   = 2'b10
    } tilt_e;

    logic signed [ACC_W-1:0]    acc_q, acc_d;
    logic [AVG_LOG2-1:0]        smp_cnt_q, smp_cnt_d;
    logic signed [SAMPLE_W-1:0] avg_q, avg_d;
    logic                       avg_vld_q, avg_vld_d;
    tilt_e                      state_q, state_d;
    tilt_e                      pend_q, pend_d;
    logic [CNT_W-1:0]           dwell_q, dwell_d;
    logic                       chg_q, chg_d;

    logic signed [ACC_W-1:0]    sum;
    tilt_e                      cand;
    logic [CNT_W-1:0]           dwell_upd;

    // Hysteresis candidate from the last completed average.
    always_comb begin
        cand = TILT_NEUTRAL;
        case (state_q)
            TILT_LEFT: begin
                if (avg_q < EXIT_NEG)        cand = TILT_LEFT;
                else if (avg_q >= ENTER_POS) cand = TILT_RIGHT;
            end
            TILT_RIGHT: begin
                if (avg_q > EXIT_POS)        cand = TILT_RIGHT;
                else if (avg_q <= ENTER_NEG) cand = TILT_LEFT;
            end
            default: begin
                if (avg_q <= ENTER_NEG)      cand = TILT_LEFT;
                else if (avg_q >= ENTER_POS) cand = TILT_RIGHT;
            end
        endcase
    end

    always_comb begin
        acc_d     = acc_q;
        smp_cnt_d = smp_cnt_q;
        avg_d     = avg_q;
        avg_vld_d = 1'b0;
        state_d   = state_q;
        pend_d    = pend_q;
        dwell_d   = dwell_q;
        chg_d     = 1'b0;

        sum       = acc_q + ACC_W'(sample_x);
        dwell_upd = (cand == pend_q) ? dwell_q + CNT_W'(1) : CNT_W'(1);

        if (sample_valid) begin
            if (smp_cnt_q == LAST_SMP) begin
                avg_d     = SAMPLE_W'(sum >>> AVG_LOG2);
                acc_d     = '0;
                smp_cnt_d = '0;
                avg_vld_d = 1'b1;
            end else begin
                acc_d     = sum;
                smp_cnt_d = smp_cnt_q + AVG_LOG2'(1);
            end
        end

        // Dwell: a disagreeing candidate must persist DWELL averages to commit.
        if (avg_vld_q) begin
            if (cand == state_q) begin
                dwell_d = '0;
            end else begin
                pend_d  = cand;
                dwell_d = dwell_upd;
                if (dwell_upd == DWELL_CNT) begin
                    state_d = cand;
                    dwell_d = '0;
                    chg_d   = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q     <= '0;
            smp_cnt_q <= '0;
            avg_q     <= '0;
            avg_vld_q <= 1'b0;
            state_q   <= TILT_NEUTRAL;
            pend_q    <= TILT_NEUTRAL;
            dwell_q   <= '0;
            chg_q     <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            smp_cnt_q <= smp_cnt_d;
            avg_q     <= avg_d;
            avg_vld_q <= avg_vld_d;
            state_q   <= state_d;
            pend_q    <= pend_d;
            dwell_q   <= dwell_d;
            chg_q     <= chg_d;
        end
    end

    assign tilt        = state_q;
    assign tilt_change = chg_q;
    assign avg_x       = avg_q;

endmodule

// File: tb/tb_tilt_classifier.sv
// Bench for tilt_classifier: directed scenarios plus randomized sample streams,
// checked cycle by cycle against an arithmetic reference model.
module tb_tilt_classifier;

    localparam int SW  = 12;
    localparam int N   = 4;
    localparam int ENT = 300;
    localparam int EXT = 150;
    localparam int DW  = 8;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 sample_valid;
    logic signed [SW-1:0] sample_x;
    logic [1:0]           tilt;
    logic                 tilt_change;
    logic signed [SW-1:0] avg_x;

    always #5 clk = ~clk;

    tilt_classifier dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sample_valid (sample_valid),
        .sample_x     (sample_x),
        .tilt         (tilt),
        .tilt_change  (tilt_change),
        .avg_x        (avg_x)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: expected outputs for the current cycle.
    int m_q[$];
    int m_avg, m_tilt, m_chg, m_pend, m_cnt;
    bit m_avg_rdy;
    int chg_seen;
    bit saw_neutral;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int floor_div(input int s);
        if (s >= 0) return s / N;
        return -((-s + N - 1) / N);
    endfunction

    // 0 neutral, 1 left, 2 right
    function automatic int cand_of(input int st, input int a);
        if (st == 1) begin
            if (a < -EXT) return 1;
            if (a >= ENT) return 2;
            return 0;
        end else if (st == 2) begin
            if (a > EXT) return 2;
            if (a <= -ENT) return 1;
            return 0;
        end
        if (a <= -ENT) return 1;
        if (a >= ENT) return 2;
        return 0;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_avg = 0; m_tilt = 0; m_chg = 0; m_pend = 0; m_cnt = 0;
        m_avg_rdy = 1'b0;
    endtask

    // One clock: check outputs, drive inputs, advance the model past the next edge.
    task automatic step(input bit v, input int x);
        int c, s;
        @(negedge clk);
        check("tilt", tilt, m_tilt);
        check("tilt_change", tilt_change, m_chg);
        check("avg_x", avg_x, m_avg);
        if (tilt_change) chg_seen++;
        if (tilt == 2'b00) saw_neutral = 1'b1;
        sample_valid = v;
        sample_x     = SW'(x);
        m_chg = 0;
        if (m_avg_rdy) begin
            c = cand_of(m_tilt, m_avg);
            if (c == m_tilt) m_cnt = 0;
            else begin
                if (c == m_pend) m_cnt++;
                else begin m_pend = c; m_cnt = 1; end
                if (m_cnt == DW) begin m_tilt = m_pend; m_cnt = 0; m_chg = 1; end
            end
        end
        m_avg_rdy = 1'b0;
        if (v) begin
            m_q.push_back(x);
            if (m_q.size() == N) begin
                s = 0;
                foreach (m_q[i]) s += m_q[i];
                m_avg = floor_div(s);
                m_q.delete();
                m_avg_rdy = 1'b1;
            end
        end
    endtask

    task automatic run(input int cnt, input int x);
        for (int i = 0; i < cnt; i++) step(1'b1, x);
    endtask

    task automatic idle(input int cnt);
        for (int i = 0; i < cnt; i++) step(1'b0, 0);
    endtask

    // Asynchronous reset pulse mid-cycle, held across one rising edge.
    task automatic pulse_reset();
        @(negedge clk);
        sample_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_tilt", tilt, 0);
        check("rst_change", tilt_change, 0);
        check("rst_avg", avg_x, 0);
        model_reset();
        @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    initial begin
        int cs, lvl, x, dur;
        rst_n = 1'b0; sample_valid = 1'b0; sample_x = '0;
        chg_seen = 0; saw_neutral = 1'b0;
        model_reset();
        #1;
        check("init_tilt", tilt, 0);
        check("init_avg", avg_x, 0);
        #20;
        @(posedge clk);
        #2 rst_n = 1'b1;

        // Floor rounding of a small negative sum.
        step(1'b1, -1); run(3, 0); idle(3);
        check("s1_avg", avg_x, -1);
        check("s1_tilt", tilt, 0);

        // Enter RIGHT.
        cs = chg_seen;
        run(32, 400); idle(3);
        check("s2_tilt", tilt, 2);
        check("s2_pulses", chg_seen - cs, 1);
        check("s2_avg", avg_x, 400);

        // Hysteresis hold, then release to NEUTRAL.
        run(64, 200); idle(3);
        check("s3_hold", tilt, 2);
        run(32, 100); idle(3);
        check("s3_release", tilt, 0);

        // Interrupted dwell restarts.
        run(28, -400); run(4, 0); idle(3);
        check("s4_a", tilt, 0);
        run(28, -400); idle(3);
        check("s4_b", tilt, 0);
        run(4, -400); idle(3);
        check("s4_c", tilt, 1);

        // Direct LEFT->RIGHT, then RIGHT->LEFT with no NEUTRAL in between.
        run(32, 400); idle(3);
        check("s5_right", tilt, 2);
        cs = chg_seen; saw_neutral = 1'b0;
        run(32, -500); idle(3);
        check("s5_left", tilt, 1);
        check("s5_pulses", chg_seen - cs, 1);
        check("s5_no_neutral", int'(saw_neutral), 0);

        // Reset discards partial sum; gapped valid.
        run(3, -2048);
        pulse_reset();
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 400); idle(2);
        end
        idle(2);
        check("s6_avg", avg_x, 400);
        check("s6_tilt", tilt, 0);

        // Randomized level runs with noise, gaps and occasional reset.
        for (int blk = 0; blk < 120; blk++) begin
            if ($urandom_range(0, 7) == 0) lvl = int'($urandom_range(0, 4095)) - 2048;
            else lvl = int'($urandom_range(0, 1400)) - 700;
            dur = int'($urandom_range(8, 60));
            for (int i = 0; i < dur; i++) begin
                x = lvl + int'($urandom_range(0, 100)) - 50;
                if (x > 2047) x = 2047;
                if (x < -2048) x = -2048;
                step($urandom_range(0, 3) != 0, x);
            end
            if ($urandom_range(0, 39) == 0) pulse_reset();
        end
        idle(4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/tilt_classifier.md
# tilt_classifier

Converts raw signed X-axis accelerometer samples into the debounced 2-bit tilt code consumed by `letter_decoder` as `tilt_input`. It has three stages:
- a block averager over 2^AVG_LOG2 samples,
- a three-state hysteresis classifier,
- a dwell counter that commits a new tilt only after DWELL consecutive agreeing averages.

It sits between the accelerometer sample interface and `letter_decoder`.

## Interface
- SAMPLE_W, 12, sample width (signed, two's complement)
- AVG_LOG2, 2, log2 of samples per average (1..4)
- ENTER_TH, 300, magnitude an average must reach to enter LEFT/RIGHT
- EXIT_TH, 150, magnitude below which LEFT/RIGHT is abandoned; 0 <= EXIT_TH < ENTER_TH < 2^(SAMPLE_W-1)
- DWELL, 8, consecutive agreeing averages required to change state (1..255)

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  asynchronous active-low reset; deassertion is synchronised by the top-level reset synchroniser
- sample_valid  in  1  qualifies sample_x; may be high on consecutive cycles
- sample_x  in  SAMPLE_W  signed X-axis acceleration
- tilt  out  2  00 neutral, 01 left (negative X), 10 right (positive X); 11 never driven
- tilt_change  out  1  one-cycle pulse in the first cycle tilt shows a new value
- avg_x  out  SAMPLE_W  last completed average (debug/VGA readout)

## Operation
- Accumulator width is SAMPLE_W+AVG_LOG2, signed, and cannot overflow.
- Each accepted sample adds to the accumulator and increments the sample counter.
- On the 2^AVG_LOG2-th sample:
  - avg_x <= (acc + sample_x) >>> AVG_LOG2 (arithmetic shift, floor toward -inf).
  - The accumulator and counter clear.
  - The internal avg_valid pulses.
- Classifier states are NEUTRAL, LEFT and RIGHT, encoded directly as the tilt code. The candidate is computed from avg_x with signed compares:
  - NEUTRAL: avg <= -ENTER_TH gives LEFT; avg >= ENTER_TH gives RIGHT; else NEUTRAL.
  - LEFT: avg < -EXIT_TH gives LEFT; avg >= ENTER_TH gives RIGHT; else NEUTRAL.
  - RIGHT: avg > EXIT_TH gives RIGHT; avg <= -ENTER_TH gives LEFT; else NEUTRAL.
- Dwell logic is evaluated only on avg_valid:
  - candidate == state: count <= 0.
  - candidate != state and candidate == pending: count <= count+1.
  - candidate != state and candidate != pending: pending <= candidate, count <= 1.
  - When the updated count equals DWELL: state <= pending, count <= 0, tilt_change pulses.
  - With DWELL=1, a single disagreeing average commits.
- A direct LEFT<->RIGHT swing is legal; it produces one change pulse with no intermediate NEUTRAL.
- Reset values:
  - tilt=00, tilt_change=0, avg_x=0.
  - Accumulator 0, sample counter 0, count 0, pending=NEUTRAL.
- Reset mid-average discards the partial sum. Reset mid-dwell discards progress.

## Timing
- Cycle k: final sample of a block accepted.
- Cycle k+1: avg_x holds the new average; avg_valid is high.
- Cycle k+2: tilt holds the new value if committed; tilt_change is high for this cycle only.
- A sample accepted in cycle k+1 begins the next block; no samples are dropped at any input rate.
- tilt is registered and glitch-free. It changes at most once per 2^AVG_LOG2 samples.
- rst_n low forces all outputs to reset values immediately, independent of clk.

## Test plan
All scenarios use the default parameters.
- Reset, then samples -1,0,0,0: avg_x = -1 (floor), tilt stays 00, no tilt_change.
- 32 samples of +400 back-to-back: tilt 00 -> 10 exactly 2 cycles after the 32nd sample; exactly one tilt_change pulse; avg_x = 400.
- From RIGHT:
  - 64 samples of +200: tilt stays 10 (hysteresis).
  - Then 32 samples of +100: tilt -> 00 after the 8th average.
- From NEUTRAL:
  - 28 samples of -400, then 4 of 0: tilt stays 00.
  - Then 28 of -400: still 00.
  - 4 more of -400: tilt -> 01.
- From RIGHT, 32 samples of -500: tilt 10 -> 01 directly; a single tilt_change pulse; never 00 in between.
- 3 samples of -2048, then rst_n low for 1 cycle, then 4 samples of +400 with sample_valid gapped 1-of-3 cycles: avg_x = 400, tilt 00.
